// File: rtl/exu_div_iter.sv
// Iterative radix-2 restoring divider, one quotient bit per cycle, RISC-V div/rem semantics.
// Define DIV_FAST_SPECIAL_EN to retire divide-by-zero and signed overflow one cycle after acceptance.
module exu_div_iter #(
    parameter int unsigned XLEN = 64
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            div_valid,
    output logic            div_ready,
    input  logic            divw,
    input  logic [1:0]      div_signed,
    input  logic [XLEN-1:0] dividend,
    input  logic [XLEN-1:0] divisor,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] quotient,
    output logic [XLEN-1:0] remainder
);

    localparam int unsigned CW = $clog2(XLEN);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t          state, state_nxt;
    logic [XLEN-1:0] dvd, dsr, prem;
    logic [CW-1:0]   cnt;
    logic            q_neg, r_neg, word, zero_div;

    logic            accept, word_in, sx_in, sy_in, zero_in;
    logic [31:0]     ax_w, ay_w;
    logic [XLEN-1:0] ax_full, ay_full, dvd_in, dsr_in;
    logic [XLEN:0]   shifted, diff;
    logic            qbit;
    logic [XLEN-1:0] prem_nxt, dvd_nxt, quo_c, rem_c, q_fin, r_fin;
`ifdef DIV_FAST_SPECIAL_EN
    logic            ovf_in;
    logic [XLEN-1:0] eff_x;
`endif

    // Operand conditioning at acceptance
    always_comb begin
        accept  = (state == IDLE) && div_valid && !flush;
        word_in = (XLEN == 64) && divw;
        sx_in   = div_signed[1] & (word_in ? dividend[31] : dividend[XLEN-1]);
        sy_in   = div_signed[0] & (word_in ? divisor[31]  : divisor[XLEN-1]);
        ax_full = sx_in ? -dividend : dividend;
        ay_full = sy_in ? -divisor  : divisor;
        ax_w    = sx_in ? -dividend[31:0] : dividend[31:0];
        ay_w    = sy_in ? -divisor[31:0]  : divisor[31:0];
        // Word dividends sit in the top 32 bits so 32 shifts consume them exactly.
        dvd_in  = word_in ? (XLEN'(ax_w) << (XLEN - 32)) : ax_full;
        dsr_in  = word_in ? XLEN'(ay_w) : ay_full;
        zero_in = word_in ? (divisor[31:0] == '0) : (divisor == '0);
`ifdef DIV_FAST_SPECIAL_EN
        ovf_in  = (div_signed == 2'b11) &&
                  (word_in ? ((dividend[31:0] == 32'h8000_0000) && (divisor[31:0] == '1))
                           : ((dividend == {1'b1, {(XLEN-1){1'b0}}}) && (divisor == '1)));
        eff_x   = word_in ? XLEN'($signed(dividend[31:0])) : dividend;
`endif
    end

    // One restoring step; quotient bits shift into the vacated dividend LSBs
    always_comb begin
        shifted  = {prem, dvd[XLEN-1]};
        diff     = shifted - {1'b0, dsr};
        qbit     = ~diff[XLEN];
        prem_nxt = qbit ? diff[XLEN-1:0] : shifted[XLEN-1:0];
        dvd_nxt  = {dvd[XLEN-2:0], qbit};
        quo_c    = q_neg ? -dvd_nxt  : dvd_nxt;
        rem_c    = r_neg ? -prem_nxt : prem_nxt;
        q_fin    = zero_div ? '1 : (word ? XLEN'($signed(quo_c[31:0])) : quo_c);
        r_fin    = word ? XLEN'($signed(rem_c[31:0])) : rem_c;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        div_ready = 1'b0;
        out_valid = 1'b0;
        case (state)
            IDLE: begin
                div_ready = 1'b1;
                if (accept) begin
`ifdef DIV_FAST_SPECIAL_EN
                    state_nxt = (zero_in || ovf_in) ? DONE : CALC;
`else
                    state_nxt = CALC;
`endif
                end
            end
            CALC: begin
                if (cnt == '0) state_nxt = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        if (flush) state_nxt = IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dvd       <= '0;
            dsr       <= '0;
            prem      <= '0;
            cnt       <= '0;
            q_neg     <= 1'b0;
            r_neg     <= 1'b0;
            word      <= 1'b0;
            zero_div  <= 1'b0;
            quotient  <= '0;
            remainder <= '0;
        end else if (accept) begin
            dvd      <= dvd_in;
            dsr      <= dsr_in;
            prem     <= '0;
            cnt      <= word_in ? CW'(31) : CW'(XLEN - 1);
            q_neg    <= sx_in ^ sy_in;
            r_neg    <= sx_in;
            word     <= word_in;
            zero_div <= zero_in;
`ifdef DIV_FAST_SPECIAL_EN
            if (zero_in || ovf_in) begin
                quotient  <= zero_in ? '1 : eff_x;
                remainder <= zero_in ? eff_x : '0;
            end
`endif
        end else if ((state == CALC) && !flush) begin
            dvd  <= dvd_nxt;
            prem <= prem_nxt;
            if (cnt == '0) begin
                quotient  <= q_fin;
                remainder <= r_fin;
            end else begin
                cnt <= cnt - 1'b1;
            end
        end
    end

endmodule
